// File: rtl/pipeline_control_pkg.sv
// pipeline_control_pkg: shared state encoding and constants for the pipeline controller.
// Holds FSM state codes, the HLT opcode, drain depth and stall counter width.
package pipeline_control_pkg;
    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_DRAIN    = 2'b01;
    localparam logic [1:0] ST_HALTED   = 2'b10;
    localparam logic [3:0] OPC_HLT     = 4'hF;
    localparam logic [1:0] DRAIN_DEPTH = 2'd3;
    localparam int         STALL_CNT_W = 16;
endpackage

// File: rtl/pipeline_control_sat_counter.sv
// sat_counter: up counter that stops at all-ones instead of wrapping.
// Ports: clk, rst_n (async active-low), en (count this edge), count (current value).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (en && count != '1) count <= count + 1'b1;
    end
endmodule

// File: rtl/pipeline_control.sv
// pipeline_control: stall/flush/freeze/halt control for a 5-stage pipeline.
// Inputs: clk, rst_n (async active-low), stall_req, branch_taken, halt_id, mem_busy.
// Outputs: pc_we, ifid_we, ifid_flush, idex_bubble, down_we (combinational),
//          halted and stall_cycles (registered).
module pipeline_control
    import pipeline_control_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall_req,
    input  logic                   branch_taken,
    input  logic                   halt_id,
    input  logic                   mem_busy,
    output logic                   pc_we,
    output logic                   ifid_we,
    output logic                   ifid_flush,
    output logic                   idex_bubble,
    output logic                   down_we,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cycles
);
    logic [1:0] state, state_nxt;
    logic [1:0] drain_cnt, drain_nxt;

    // mem_busy freezes everything; reset forces all enables low.
    always_comb begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        down_we     = 1'b0;
        state_nxt   = state;
        drain_nxt   = drain_cnt;
        if (!rst_n || mem_busy) begin
        end else if (state == ST_DRAIN) begin
            ifid_we    = 1'b1;
            ifid_flush = 1'b1;
            down_we    = 1'b1;
            drain_nxt  = drain_cnt - 1'b1;
            state_nxt  = (drain_cnt == 2'd1) ? ST_HALTED : ST_DRAIN;
        end else if (state == ST_HALTED) begin
        end else begin
            state_nxt = ST_RUN;
            if (stall_req) begin
                idex_bubble = 1'b1;
                down_we     = 1'b1;
            end else if (halt_id) begin
                // HLT proceeds downstream while fetch stops and IF/ID fills with NOPs.
                ifid_we    = 1'b1;
                ifid_flush = 1'b1;
                down_we    = 1'b1;
                state_nxt  = ST_DRAIN;
                drain_nxt  = DRAIN_DEPTH;
            end else begin
                pc_we      = 1'b1;
                ifid_we    = 1'b1;
                ifid_flush = branch_taken;
                down_we    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            drain_cnt <= 2'd0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    assign halted = (state == ST_HALTED);

    sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (!pc_we && state != ST_HALTED),
        .count (stall_cycles)
    );
endmodule

// File: doc/pipeline_control.md
PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, async active-low reset.
REQ-002 SHALL have stall_req input 1: load-use/branch-operand stall request from the hazard detector (combinational, same cycle).
REQ-003 SHALL have branch_taken input 1: branch resolved taken in ID.
REQ-004 SHALL have halt_id input 1: HLT opcode (4'hF) present in IF/ID.
REQ-005 SHALL have mem_busy input 1: multi-cycle memory access in progress; freezes the whole pipeline.
REQ-006 SHALL have pc_we output 1: PC write enable.
REQ-007 SHALL have ifid_we output 1: IF/ID write enable.
REQ-008 SHALL have ifid_flush output 1: load NOP into IF/ID.
REQ-009 SHALL have idex_bubble output 1: load NOP (all control 0) into ID/EX.
REQ-010 SHALL have down_we output 1: write enable for ID/EX, EX/MEM and MEM/WB.
REQ-011 SHALL have halted output 1: processor halted.
REQ-012 SHALL have stall_cycles output 16: saturating count of stalled cycles.

Function
REQ-013 SHALL implement FSM states RUN, DRAIN and HALTED; all outputs except stall_cycles and halted SHALL be combinational from state and inputs.
REQ-014 SHALL apply this priority, highest first: mem_busy, state (DRAIN/HALTED), stall_req, halt_id, branch_taken.
REQ-015 When mem_busy=1 in any state, pc_we, ifid_we and down_we SHALL be 0; ifid_flush and idex_bubble SHALL be 0; state and drain counter SHALL hold.
REQ-016 In RUN with stall_req=1, outputs SHALL be pc_we=0, ifid_we=0, idex_bubble=1, down_we=1, ifid_flush=0, and branch_taken and halt_id SHALL be ignored.
REQ-017 In RUN with branch_taken=1 and no higher-priority event, outputs SHALL be pc_we=1, ifid_we=1, ifid_flush=1, down_we=1.
REQ-018 In RUN with halt_id=1 and no higher-priority event, outputs SHALL be pc_we=0, ifid_flush=1, down_we=1, and the next state SHALL be DRAIN with the drain counter loaded to 3.
REQ-019 In RUN with no event, pc_we, ifid_we and down_we SHALL be 1, and ifid_flush and idex_bubble SHALL be 0.
REQ-020 In DRAIN, outputs SHALL be pc_we=0, ifid_flush=1, down_we=1.
REQ-021 In DRAIN, the 2-bit drain counter SHALL decrement once per non-frozen cycle, and the FSM SHALL enter HALTED on the cycle the counter is 1 and decrements, so the HLT instruction reaches WB.
REQ-022 In DRAIN, stall_req, branch_taken and halt_id SHALL be ignored.
REQ-023 In HALTED, all write enables SHALL be 0, halted SHALL be 1 (registered), and the state SHALL be held until reset.
REQ-024 stall_cycles SHALL increment by 1 on every clock edge, in RUN or DRAIN, where pc_we=0, and SHALL saturate at 16'hFFFF without wrap.
REQ-025 stall_cycles SHALL NOT increment in HALTED.

Reset
REQ-026 While rst_n=0, state SHALL be RUN, the drain counter 0, stall_cycles 0 and halted 0, and pc_we, ifid_we and down_we SHALL be 0.
REQ-027 Reset asserted mid-DRAIN or in HALTED SHALL return the block to RUN immediately, with no further edges required.

Structure
REQ-028 A shared package SHALL hold the state encoding (RUN=2'b00, DRAIN=2'b01, HALTED=2'b10), OPC_HLT=4'hF, DRAIN_DEPTH=3 and STALL_CNT_W=16.
REQ-029 The saturating counter SHALL be one sub-module, sat_counter, parameterised by width, with enable and async active-low reset.

Verification
REQ-030 Verification SHALL cover: stall_req=1 for 1 cycle in RUN -> pc_we=0, ifid_we=0, idex_bubble=1 that cycle, and stall_cycles goes 0->1.
REQ-031 Verification SHALL cover: stall_req=1 and branch_taken=1 together -> stall response only (ifid_flush=0); branch_taken=1 on the next cycle alone -> ifid_flush=1, pc_we=1.
REQ-032 Verification SHALL cover: halt_id=1 -> DRAIN for 3 cycles with pc_we=0 and ifid_flush=1, then halted=1 and all write enables 0 thereafter.
REQ-033 Verification SHALL cover: mem_busy=1 for 4 cycles in the middle of DRAIN -> counter frozen, halted asserted 4 cycles later than without it, and stall_cycles increases by the number of pc_we=0 cycles.
REQ-034 Verification SHALL cover: stall_cycles preloaded near saturation via a long mem_busy run (65540 cycles) -> stall_cycles holds at 16'hFFFF.
REQ-035 Verification SHALL cover: rst_n pulsed low asynchronously (not aligned to clk) while HALTED -> state RUN, halted=0, stall_cycles=0 before the next clk edge.
